// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: geometry presets and sync polarity encoding shared by the raster timing blocks
package vga_timing_gen_pkg;
  localparam bit POL_NEG = 1'b0;
  localparam bit POL_POS = 1'b1;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
    bit pol;
  } axis_geom_t;
  localparam axis_geom_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48, pol: POL_NEG};
  localparam axis_geom_t VGA640_V = '{active: 480, fp: 10, sync: 2, bp: 33, pol: POL_NEG};
  localparam axis_geom_t SVGA800_H = '{active: 800, fp: 56, sync: 120, bp: 64, pol: POL_POS};
  localparam axis_geom_t SVGA800_V = '{active: 600, fp: 37, sync: 6, bp: 23, pol: POL_POS};
  function automatic int axis_total(int a, int f, int s, int b);
    return a + f + s + b;
  endfunction
endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one raster axis -- wrapping position counter with active and sync decode
module vga_axis_counter import vga_timing_gen_pkg::*; #(
  parameter int ACTIVE = 640,
  parameter int FP = 16,
  parameter int SYNC = 96,
  parameter int BP = 48,
  parameter int W = 10,
  parameter bit POL = POL_NEG
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         at_end,
  output logic         active,
  output logic         sync
);
  localparam logic [W-1:0] LAST = W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [W-1:0] S_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_HI = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] A_END = W'(ACTIVE);
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) count <= '0;
    else if (clear) count <= '0;
    else if (step) count <= at_end ? '0 : count + 1'b1;
  always_comb begin
    at_end = count == LAST;
    active = count < A_END;
    sync = (count >= S_LO && count <= S_HI) ? POL : ~POL;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with run gating, prefetch strobe and pipeline-matched sync outputs
module vga_timing_gen import vga_timing_gen_pkg::*; #(
  parameter int H_ACTIVE = VGA640_H.active,
  parameter int H_FP = VGA640_H.fp,
  parameter int H_SYNC = VGA640_H.sync,
  parameter int H_BP = VGA640_H.bp,
  parameter int V_ACTIVE = VGA640_V.active,
  parameter int V_FP = VGA640_V.fp,
  parameter int V_SYNC = VGA640_V.sync,
  parameter int V_BP = VGA640_V.bp,
  parameter bit H_SYNC_POL = VGA640_H.pol,
  parameter bit V_SYNC_POL = VGA640_V.pol,
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int PREFETCH = 8,
  parameter int SYNC_DELAY = 2
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          ce,
  input  logic          enable,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          hactive,
  output logic          vactive,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          active_d,
  output logic          line_pulse,
  output logic          frame_pulse,
  output logic          vblank_pulse,
  output logic          prefetch_pulse,
  output logic [VW-1:0] next_vpos
);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam logic [HW-1:0] H_PF = HW'(H_TOTAL - PREFETCH);
  localparam logic [VW-1:0] V_LAST_VIS = VW'(V_ACTIVE - 1);
  logic run, step, h_end, v_end, h_act, v_act, h_sync, v_sync;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) run <= 1'b0;
    else run <= enable;
  // counters only advance once run is up, so the first running cycle sits at 0,0
  assign step = ce & run;
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW), .POL(H_SYNC_POL)
  ) u_h (
    .clk(clk), .nRst(nRst), .step(step), .clear(!enable),
    .count(hpos), .at_end(h_end), .active(h_act), .sync(h_sync)
  );
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW), .POL(V_SYNC_POL)
  ) u_v (
    .clk(clk), .nRst(nRst), .step(step & h_end), .clear(!enable),
    .count(vpos), .at_end(v_end), .active(v_act), .sync(v_sync)
  );
  always_comb begin
    hactive = run & h_act;
    vactive = run & v_act;
    active = hactive & vactive;
    hsync = run ? h_sync : ~H_SYNC_POL;
    vsync = run ? v_sync : ~V_SYNC_POL;
    line_pulse = step & h_end;
    frame_pulse = line_pulse & v_end;
    vblank_pulse = line_pulse & (vpos == V_LAST_VIS);
    next_vpos = v_end ? '0 : vpos + 1'b1;
    prefetch_pulse = step & (hpos == H_PF) & (v_end | (vpos < V_LAST_VIS));
  end
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign hsync_d = hsync;
      assign vsync_d = vsync;
      assign active_d = active;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hp, vp, ap;
      always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
          hp <= {SYNC_DELAY{~H_SYNC_POL}};
          vp <= {SYNC_DELAY{~V_SYNC_POL}};
          ap <= '0;
        end else if (!enable) begin
          hp <= {SYNC_DELAY{~H_SYNC_POL}};
          vp <= {SYNC_DELAY{~V_SYNC_POL}};
          ap <= '0;
        end else if (ce) begin
          hp <= SYNC_DELAY'({hp, hsync});
          vp <= SYNC_DELAY'({vp, vsync});
          ap <= SYNC_DELAY'({ap, active});
        end
      assign hsync_d = hp[SYNC_DELAY-1];
      assign vsync_d = vp[SYNC_DELAY-1];
      assign active_d = ap[SYNC_DELAY-1];
    end
  endgenerate
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator, the successor to the fixed 640x480 timing block. It supports arbitrary porch, sync and active geometry, per-axis sync polarity, and a pixel clock-enable for dividing a faster system clock. It also provides a soft run enable, a next-line prefetch pulse for the line renderer, and sync/active outputs delayed to match the pixel pipeline. It sits between the clock/reset logic and the game renderer and pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, hsync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vsync width, in lines
V_BP, 33, vertical back porch, in lines
H_SYNC_POL, 0, 0 = active-low hsync, 1 = active-high
V_SYNC_POL, 0, same encoding for vsync
HW, 10, hpos counter width; must satisfy 2^HW >= H_TOTAL
VW, 10, vpos counter width; must satisfy 2^VW >= V_TOTAL
PREFETCH, 8, pixels before line wrap at which prefetch_pulse fires; legal range 1..H_FP+H_SYNC+H_BP
SYNC_DELAY, 2, pixel-step delay for the *_d outputs; 0 means combinational pass-through

Ports:
clk  in  1  pixel/system clock
nRst  in  1  asynchronous reset, active-low
ce  in  1  pixel advance enable
enable  in  1  soft run; low parks the generator
hpos  out  HW  horizontal counter
vpos  out  VW  vertical counter
hactive  out  1  hpos < H_ACTIVE
vactive  out  1  vpos < V_ACTIVE
active  out  1  hactive & vactive
hsync  out  1  hsync, polarity applied
vsync  out  1  vsync, polarity applied
hsync_d  out  1  hsync delayed SYNC_DELAY pixel steps
vsync_d  out  1  vsync delayed SYNC_DELAY pixel steps
active_d  out  1  active delayed SYNC_DELAY pixel steps
line_pulse  out  1  end-of-line strobe
frame_pulse  out  1  end-of-frame strobe
vblank_pulse  out  1  last visible line finished
prefetch_pulse  out  1  renderer may start fetching the next line
next_vpos  out  VW  line number the prefetch refers to

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- run register:
  - Resets to 0; run <= enable on every clk.
- Counters (hpos, vpos) reset to 0. On each clk edge:
  - enable=0: hpos <= 0, vpos <= 0.
  - else if ce=1: hpos increments, wrapping H_TOTAL-1 -> 0.
  - vpos increments only on the hpos wrap, wrapping V_TOTAL-1 -> 0.
  - ce=0: counters hold.
- Decoded outputs are valid in the same cycle as the hpos/vpos they describe:
  - hactive = run & (hpos < H_ACTIVE); vactive = run & (vpos < V_ACTIVE).
  - hsync is asserted iff run & hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is asserted iff run & vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Asserted level = *_POL; deasserted level = ~*_POL.
- Pulses are exactly 1 clk wide, and only when ce=1 and run=1:
  - line_pulse: hpos == H_TOTAL-1.
  - frame_pulse: line_pulse & vpos == V_TOTAL-1.
  - vblank_pulse: line_pulse & vpos == V_ACTIVE-1.
  - prefetch_pulse: hpos == H_TOTAL-PREFETCH and the next line is visible.
    - The next line is visible when vpos == V_TOTAL-1 or vpos <= V_ACTIVE-2.
    - next_vpos = (vpos == V_TOTAL-1) ? 0 : vpos+1. It is valid whenever prefetch_pulse is high and otherwise don't-care.
- Delay pipes (*_d) shift only when ce=1:
  - Reset and enable=0 fill them with idle values: sync deasserted, active_d = 0.
  - With SYNC_DELAY=0, *_d equal the undelayed signals.
- Reset/idle values: hpos = vpos = 0, hactive = vactive = active = 0, hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, all pulses 0.
- First running cycle: hpos = 0, vpos = 0, active = 1.
- Reset asserted mid-frame: immediate asynchronous return to the idle values, no glitch on the syncs beyond the transition to the deasserted level.
- enable dropped mid-line: counters reach 0 on the next edge and outputs go idle one clk later via run. No partial pulses are emitted.

Decomposition:
- Shared header vga_timing_defs: geometry constant sets for 640x480@60 (default) and 800x600@72, plus a polarity encoding constant.
- One sub-module, vga_axis_counter, instantiated once for H and once for V.
  - Parameters: ACTIVE, FP, SYNC, BP, W, POL.
  - Inputs: step, clear. Outputs: count, at_end, active, sync.

Test Plan:
- Default params, enable=1, ce=1 -> line_pulse every 800 clk; frame_pulse every 420000 clk; vblank_pulse at hpos=799 on vpos=479.
- Default params -> hsync low exactly for hpos 656..751; vsync low exactly for vpos 490..491; active high exactly 640x480 pixels per frame.
- ce toggling 1/0 -> line_pulse period 1600 clk, each pulse 1 clk wide; counters hold on ce=0 cycles.
- Small config H 8/2/2/2, V 4/1/1/1, POL=1, SYNC_DELAY=2 -> hsync high at hpos 10..11; hsync_d and active_d lag by exactly 2 ce steps.
- Default PREFETCH=8 -> prefetch_pulse at hpos=792 for vpos=524 (next_vpos=0) and vpos 0..478 (next_vpos=vpos+1); absent for vpos 479..523.
- Cases:
  - enable low at hpos=300/vpos=100 -> counters 0 next clk, outputs idle one clk later; re-enable restarts at 0,0 with active=1.
  - nRst pulse mid-frame -> immediate reset values.
